fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage directly upstream of the decode stage. Keeps the program counter, issues one-outstanding requests to instruction memory, buffers returned instructions in a small queue, and presents a registered IF/ID output (instruction, PC+8, valid) to decode. Supports decode stalls and taken-branch redirects with discard of in-flight responses.

## Interface
- WIDTH, 8, data/PC width; matches the decode stage data width
- INSTRUCTIONWIDTH, 16, instruction width
- PCSTEP, 4, PC increment per instruction (byte addressing)
- RESETPC, 0, PC value after reset
- QDEPTH, 2, fetch queue depth (power of two, ≥2)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- imemAddress  out  WIDTH  fetch address; equals fetchPC
- imemRequest  out  1  request strobe; one request accepted per cycle asserted
- imemData  in  INSTRUCTIONWIDTH  returned instruction, valid with imemValid
- imemValid  in  1  response strobe, ≥1 cycle after the accepted request
- stall  in  1  decode/hazard hold; freezes IF/ID output
- branchTaken  in  1  redirect request from execute
- branchTarget  in  WIDTH  redirect address
- instruction  out  INSTRUCTIONWIDTH  IF/ID instruction to decode
- PCPlus8  out  WIDTH  address of that instruction + 2·PCSTEP, to decode
- instructionValid  out  1  IF/ID entry holds a real instruction

## Operation
- FSM states: REQ, WAIT, DISCARD.
  - REQ: imemRequest = (count < QDEPTH); if asserted, next state WAIT, fetchPC += PCSTEP, PC of request latched as reqPC. If queue full, stay REQ with imemRequest low.
  - WAIT: on imemValid, enqueue {imemData, reqPC}; next REQ.
  - DISCARD: in-flight response is dropped on imemValid; next REQ.
- branchTaken (any state, highest priority after reset): fetchPC ← branchTarget, queue cleared, IF/ID invalidated (instructionValid 0, instruction 0) regardless of stall. If in WAIT without imemValid, or in DISCARD without imemValid → DISCARD; otherwise → REQ. No request issued in the redirect cycle.
- Same-cycle imemValid + branchTaken in WAIT: response discarded, next REQ.
- IF/ID update when stall low and no branchTaken: queue non-empty → load head, dequeue, instructionValid 1; empty → bubble (instruction 0, instructionValid 0). stall high: IF/ID and queue head hold; enqueue still permitted if space.
- Enqueue and dequeue in the same cycle allowed, including when full.
- PCPlus8 = entry PC + 2·PCSTEP, modulo 2^WIDTH; fetchPC wraps modulo 2^WIDTH with no flag.
- imemValid in REQ (stray, e.g. post-reset) is ignored.

## Timing
- Reset (reset low at edge): state REQ, fetchPC = RESETPC, queue empty, instruction = 0, PCPlus8 = 0, instructionValid = 0. imemRequest asserts combinationally in the first cycle after reset release.
- imemRequest and imemAddress are combinational from state, count, fetchPC.
- imemValid sampled at edge N with empty queue, stall low → instructionValid high after edge N+1.
- 1-cycle memory: one instruction per 2 cycles sustained.
- branchTaken at edge N → first request to branchTarget in cycle after edge N (REQ) or after in-flight response drains (DISCARD).
- Reset mid-operation overrides everything, including branchTaken and imemValid.

## Structure
- Shared package pipeline_pkg: fetch_state_t enum (REQ, WAIT, DISCARD), NOP_INSTRUCTION constant (all zeros), fetch entry struct {instruction, pc}.
- Sub-module fetch_queue: parameterised synchronous FIFO (push, pop, clear, full, empty, count, head), clear synchronous; active-low synchronous reset.

## Test plan
- Reset then 1-cycle memory returning 0x1000, 0x2000 at 0, 4 → instruction 0x1000/PCPlus8 8, then 0x2000/PCPlus8 12; first instructionValid two edges after first imemValid.
- stall held 6 cycles after first instruction → IF/ID frozen, queue fills to 2, imemRequest drops low, no lost or duplicated instruction on release.
- branchTaken target 0x40 while WAIT (3-cycle memory) → old response dropped, next request address 0x40, instructionValid 0 until 0x40 instruction arrives with PCPlus8 0x48.
- branchTaken coincident with imemValid → response dropped, request to target next cycle.
- fetchPC 0xFC → next request 0x00, PCPlus8 for 0xFC is 0x04.
- reset low mid-WAIT, stray imemValid after release → ignored, fetch restarts at RESETPC, all outputs at reset values.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch/decode types and constants
package pipeline_pkg;
  localparam int INSTR_W = 16;
  localparam int PC_W = 8;
  localparam logic [INSTR_W-1:0] NOP_INSTRUCTION = '0;
  typedef enum logic [1:0] {REQ, WAIT, DISCARD} fetch_state_t;
  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with synchronous clear and active-low sync reset
module fetch_queue #(
  parameter int DW = 24,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [DW-1:0] din_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [DW-1:0] head_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o = mem_q[rd_q];
  assign do_pop = pop_i && !empty_o;
  // a full queue still accepts a push when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_q + AW'(do_pop);
      wr_q <= wr_q + AW'(do_push);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, one-outstanding imem fetch, fetch queue and IF/ID register
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int INSTRUCTIONWIDTH = 16,
  parameter int PCSTEP = 4,
  parameter int RESETPC = 0,
  parameter int QDEPTH = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic [WIDTH-1:0]            imemAddress,
  output logic                        imemRequest,
  input  logic [INSTRUCTIONWIDTH-1:0] imemData,
  input  logic                        imemValid,
  input  logic                        stall,
  input  logic                        branchTaken,
  input  logic [WIDTH-1:0]            branchTarget,
  output logic [INSTRUCTIONWIDTH-1:0] instruction,
  output logic [WIDTH-1:0]            PCPlus8,
  output logic                        instructionValid
);
  localparam int CW = $clog2(QDEPTH) + 1;
  typedef struct packed {
    logic [INSTRUCTIONWIDTH-1:0] instruction;
    logic [WIDTH-1:0]            pc;
  } entry_t;
  fetch_state_t state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d, pc8_q, pc8_d;
  logic [INSTRUCTIONWIDTH-1:0] instr_q, instr_d;
  logic valid_q, valid_d;
  logic q_push, q_pop, q_full, q_empty;
  logic [CW-1:0] q_count;
  entry_t q_head;
  fetch_queue #(.DW($bits(entry_t)), .DEPTH(QDEPTH)) u_queue (
    .clk(clock),
    .rst_n(reset),
    .push_i(q_push),
    .pop_i(q_pop),
    .clear_i(branchTaken),
    .din_i({imemData, req_pc_q}),
    .full_o(q_full),
    .empty_o(q_empty),
    .count_o(q_count),
    .head_o(q_head)
  );
  always_comb begin
    imemAddress = pc_q;
    imemRequest = reset && !branchTaken && state_q == REQ && q_count < CW'(QDEPTH);
    q_push = !branchTaken && state_q == WAIT && imemValid && (!q_full || q_pop);
    q_pop = !stall && !branchTaken && !q_empty;
    state_d = state_q;
    pc_d = pc_q;
    req_pc_d = req_pc_q;
    if (branchTaken) begin
      pc_d = branchTarget;
      state_d = (state_q != REQ && !imemValid) ? DISCARD : REQ;
    end else if (state_q == REQ) begin
      state_d = imemRequest ? WAIT : REQ;
      pc_d = imemRequest ? pc_q + WIDTH'(PCSTEP) : pc_q;
      req_pc_d = imemRequest ? pc_q : req_pc_q;
    end else if (imemValid) begin
      state_d = REQ;
    end
    instr_d = instr_q;
    pc8_d = pc8_q;
    valid_d = valid_q;
    if (branchTaken || (!stall && q_empty)) begin
      instr_d = INSTRUCTIONWIDTH'(NOP_INSTRUCTION);
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = q_head.instruction;
      pc8_d = q_head.pc + WIDTH'(2 * PCSTEP);
      valid_d = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= REQ;
      pc_q <= WIDTH'(RESETPC);
      req_pc_q <= WIDTH'(RESETPC);
      instr_q <= '0;
      pc8_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      instr_q <= instr_d;
      pc8_q <= pc8_d;
      valid_q <= valid_d;
    end
  end
  assign instruction = instr_q;
  assign PCPlus8 = pc8_q;
  assign instructionValid = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage with a latency-programmable imem model
module tb_fetch_stage;
  logic clock = 1'b0;
  logic reset, imemRequest, imemValid, stall, branchTaken, instructionValid;
  logic [7:0] imemAddress, branchTarget, PCPlus8;
  logic [15:0] imemData, instruction;
  typedef struct packed {logic [15:0] instr; logic [7:0] pc8;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_fail = 0, budget = 0, lat = 1, n, left;
  logic upd, pend;
  logic [7:0] paddr;

  fetch_stage dut (
    .clock(clock), .reset(reset), .imemAddress(imemAddress), .imemRequest(imemRequest),
    .imemData(imemData), .imemValid(imemValid), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .instruction(instruction), .PCPlus8(PCPlus8),
    .instructionValid(instructionValid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [7:0] a);
    return a == 8'h00 ? 16'h1000 : a == 8'h04 ? 16'h2000 : {a, 8'h5A};
  endfunction

  // memory: accepts a visible request (while budget lasts), answers after lat cycles
  initial begin
    imemValid = 1'b0;
    imemData = '0;
    pend = 1'b0;
    left = 0;
    paddr = '0;
    forever begin
      @(negedge clock);
      #1;
      imemValid = 1'b0;
      if (pend) begin
        if (left == 1) begin
          imemValid = 1'b1;
          imemData = mem_rd(paddr);
          pend = 1'b0;
        end else left--;
      end
      if (!pend && imemRequest === 1'b1 && budget > 0) begin
        pend = 1'b1;
        left = lat;
        paddr = imemAddress;
        budget--;
      end
    end
  end

  // monitor: a new IF/ID entry appears after every edge that allowed an update
  initial forever begin
    @(posedge clock);
    upd = reset && !stall && !branchTaken;
    #3;
    if (upd && instructionValid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_entry: got instr 0x%0h pc8 0x%0h, want none", instruction, PCPlus8);
      end else begin
        e = sb.pop_front();
        chk("ifid_instr", instruction, e.instr);
        chk("ifid_pc8", PCPlus8, e.pc8);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int b, input int l);
    reset = 1'b0;
    stall = 1'b0;
    branchTaken = 1'b0;
    branchTarget = '0;
    repeat (4) @(negedge clock);
    #4;
    chk("rst_instr", instruction, 0);
    chk("rst_pc8", PCPlus8, 0);
    chk("rst_valid", instructionValid, 0);
    chk("rst_req", imemRequest, 0);
    @(negedge clock);
    budget = b;
    lat = l;
    reset = 1'b1;
    #4;
    chk("post_rst_req", imemRequest, 1);
    chk("post_rst_addr", imemAddress, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
    chk("drain", sb.size(), 0);
    repeat (4) @(negedge clock);
  endtask

  initial begin
    // basic 1-cycle memory stream and first-valid latency
    do_reset(2, 1);
    sb.push_back('{16'h1000, 8'h08});
    sb.push_back('{16'h2000, 8'h0C});
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(negedge clock);
      #4;
      if (instructionValid) n = i;
    end
    chk("first_valid_cycle", n, 3);
    drain();
    // stall freezes IF/ID while the queue fills
    do_reset(4, 1);
    sb.push_back('{16'h1000, 8'h08});
    sb.push_back('{16'h2000, 8'h0C});
    sb.push_back('{16'h085A, 8'h10});
    sb.push_back('{16'h0C5A, 8'h14});
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(negedge clock);
      #4;
      if (instructionValid) n = i;
    end
    chk("stall_first_valid", n, 3);
    stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clock);
        #4;
      end
      chk("stall_hold_instr", instruction, 16'h1000);
      chk("stall_hold_valid", instructionValid, 1);
    end
    chk("stall_full_req", imemRequest, 0);
    stall = 1'b0;
    drain();
    // branch during WAIT with 3-cycle memory
    do_reset(2, 3);
    sb.push_back('{16'h405A, 8'h48});
    @(negedge clock);
    branchTaken = 1'b1;
    branchTarget = 8'h40;
    #4;
    chk("br_no_req", imemRequest, 0);
    @(negedge clock);
    branchTaken = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      #4;
      if (imemRequest) n = i + 2;
      else chk("br_bubble", instructionValid, 0);
      if (n == 0) @(negedge clock);
    end
    chk("br_req_cycle", n, 4);
    chk("br_req_addr", imemAddress, 8'h40);
    drain();
    // branch coincident with the response
    do_reset(2, 1);
    sb.push_back('{16'h805A, 8'h88});
    @(negedge clock);
    branchTaken = 1'b1;
    branchTarget = 8'h80;
    @(negedge clock);
    branchTaken = 1'b0;
    #4;
    chk("coinc_req", imemRequest, 1);
    chk("coinc_addr", imemAddress, 8'h80);
    drain();
    // PC wrap at 0xFC
    do_reset(3, 1);
    sb.push_back('{16'hFC5A, 8'h04});
    sb.push_back('{16'h1000, 8'h08});
    @(negedge clock);
    branchTaken = 1'b1;
    branchTarget = 8'hFC;
    @(negedge clock);
    branchTaken = 1'b0;
    #4;
    chk("wrap_addr_fc", imemAddress, 8'hFC);
    repeat (2) @(negedge clock);
    #4;
    chk("wrap_req", imemRequest, 1);
    chk("wrap_addr_00", imemAddress, 8'h00);
    drain();
    // reset mid-WAIT, stray response right after release
    do_reset(3, 3);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #4;
    chk("midrst_req", imemRequest, 0);
    @(negedge clock);
    reset = 1'b1;
    sb.push_back('{16'h1000, 8'h08});
    sb.push_back('{16'h2000, 8'h0C});
    #4;
    chk("midrst_req_rel", imemRequest, 1);
    chk("midrst_addr", imemAddress, 0);
    chk("midrst_valid", instructionValid, 0);
    chk("midrst_instr", instruction, 0);
    chk("midrst_pc8", PCPlus8, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
